// File: rtl/sprite_arb_pkg.sv
// ---------------------------------------------------------------------------
// sprite_arb_pkg
//   Shared types and defaults for the sprite RAM arbiter.
//   - scan_state_e : sprite scanner FSM states (IDLE / SCAN)
//   - grantee_e    : owner of the RAM for one CLK_6M cycle
//   - *_DEFAULT    : default values for BASE / NUM_SPR / ENTRY_BYTES
//   - in_window()  : address range test used by the optional scan lock
//                    (SPRITE_ARB_SCAN_LOCK_EN build of the top level)
// ---------------------------------------------------------------------------
package sprite_arb_pkg;

    localparam logic [12:0] BASE_DEFAULT        = 13'h1800;
    localparam int          NUM_SPR_DEFAULT     = 128;
    localparam int          ENTRY_BYTES_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SUB  = 2'd1,
        GNT_MAIN = 2'd2,
        GNT_SCAN = 2'd3
    } grantee_e;

    // True when addr lies in [base, base + len).
    function automatic logic in_window(input logic [12:0] addr,
                                       input logic [12:0] base,
                                       input int unsigned len);
        int unsigned a;
        int unsigned b;
        a = 32'(addr);
        b = 32'(base);
        return (a >= b) && (a < b + len);
    endfunction

endpackage

// File: rtl/sprite_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_scan_ctrl
//   Sprite table scanner: FSM (IDLE/SCAN) plus address generator. A rising
//   edge on vreset (sampled on clk) starts a scan at idx=0, byte=0. Each
//   granted read returns one scan_valid pulse one cycle after the grant.
//
//   Ports
//     clk, rst_n        : pixel clock, async active-low reset
//     vreset            : frame start; rising edge (re)starts the scan
//     scan_gnt          : arbiter grants the scanner this cycle
//     ram_di            : RAM read data, sampled one cycle after the grant
//     scan_req          : scanner wants the RAM (FSM in SCAN)
//     scan_addr         : BASE + idx*ENTRY_BYTES + byte, 13 bits
//     scan_d/idx/byte   : data and position of the returned read
//     scan_valid        : one pulse per completed scan read
//     scan_done         : pulses with scan_valid of the final read
// ---------------------------------------------------------------------------
module sprite_scan_ctrl
    import sprite_arb_pkg::*;
#(
    parameter logic [12:0] BASE        = BASE_DEFAULT,
    parameter int          NUM_SPR     = NUM_SPR_DEFAULT,
    parameter int          ENTRY_BYTES = ENTRY_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vreset,
    input  logic        scan_gnt,
    input  logic [7:0]  ram_di,
    output logic        scan_req,
    output logic [12:0] scan_addr,
    output logic [7:0]  scan_d,
    output logic [6:0]  scan_idx,
    output logic [2:0]  scan_byte,
    output logic        scan_valid,
    output logic        scan_done
);

    localparam logic [6:0] IDX_LAST  = 7'(NUM_SPR - 1);
    localparam logic [2:0] BYTE_LAST = 3'(ENTRY_BYTES - 1);

    scan_state_e state_q, state_d;

    logic       vreset_q, vreset_d;
    logic [6:0] idx_q, idx_d;
    logic [2:0] byte_q, byte_d;
    logic       inflight_q, inflight_d;
    logic [6:0] fl_idx_q, fl_idx_d;
    logic [2:0] fl_byte_q, fl_byte_d;
    logic       fl_last_q, fl_last_d;
    logic [7:0] scan_d_q, scan_d_d;
    logic [6:0] scan_idx_q, scan_idx_d;
    logic [2:0] scan_byte_q, scan_byte_d;
    logic       scan_valid_q, scan_valid_d;
    logic       scan_done_q, scan_done_d;

    logic vreset_rise;
    logic is_last;

    assign vreset_rise = vreset & ~vreset_q;
    assign is_last     = (idx_q == IDX_LAST) && (byte_q == BYTE_LAST);

    // ---- FSM: state register ----------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would chain flops together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----------------------------------------------------
    // NOTE: every always_comb output gets a default on entry; a path that
    // leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (vreset_rise) state_d = ST_SCAN;
            ST_SCAN: begin
                if (vreset_rise) begin
                    state_d = ST_SCAN;
                end else if (scan_gnt && is_last) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // ---- FSM: outputs -------------------------------------------------------
    always_comb begin
        scan_req = (state_q == ST_SCAN);
    end

    assign scan_addr = BASE + (13'(idx_q) * 13'(ENTRY_BYTES)) + 13'(byte_q);

    // ---- Address counters and read tracking ---------------------------------
    always_comb begin
        vreset_d    = vreset;
        idx_d       = idx_q;
        byte_d      = byte_q;
        fl_idx_d    = fl_idx_q;
        fl_byte_d   = fl_byte_q;
        fl_last_d   = fl_last_q;
        scan_d_d    = scan_d_q;
        scan_idx_d  = scan_idx_q;
        scan_byte_d = scan_byte_q;

        if (vreset_rise) begin
            idx_d  = '0;
            byte_d = '0;
        end else if (scan_gnt) begin
            if (byte_q == BYTE_LAST) begin
                byte_d = '0;
                idx_d  = idx_q + 7'd1;
            end else begin
                byte_d = byte_q + 3'd1;
            end
        end

        if (scan_gnt) begin
            fl_idx_d  = idx_q;
            fl_byte_d = byte_q;
            fl_last_d = is_last;
        end

        // A restart cancels both the read being granted now and the one
        // whose data lands at this edge; neither belongs to the new scan.
        inflight_d   = scan_gnt & ~vreset_rise;
        scan_valid_d = inflight_q & ~vreset_rise;
        scan_done_d  = scan_valid_d & fl_last_q;

        if (scan_valid_d) begin
            scan_d_d    = ram_di;
            scan_idx_d  = fl_idx_q;
            scan_byte_d = fl_byte_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vreset_q     <= 1'b0;
            idx_q        <= '0;
            byte_q       <= '0;
            inflight_q   <= 1'b0;
            fl_idx_q     <= '0;
            fl_byte_q    <= '0;
            fl_last_q    <= 1'b0;
            scan_d_q     <= '0;
            scan_idx_q   <= '0;
            scan_byte_q  <= '0;
            scan_valid_q <= 1'b0;
            scan_done_q  <= 1'b0;
        end else begin
            vreset_q     <= vreset_d;
            idx_q        <= idx_d;
            byte_q       <= byte_d;
            inflight_q   <= inflight_d;
            fl_idx_q     <= fl_idx_d;
            fl_byte_q    <= fl_byte_d;
            fl_last_q    <= fl_last_d;
            scan_d_q     <= scan_d_d;
            scan_idx_q   <= scan_idx_d;
            scan_byte_q  <= scan_byte_d;
            scan_valid_q <= scan_valid_d;
            scan_done_q  <= scan_done_d;
        end
    end

    assign scan_d     = scan_d_q;
    assign scan_idx   = scan_idx_q;
    assign scan_byte  = scan_byte_q;
    assign scan_valid = scan_valid_q;
    assign scan_done  = scan_done_q;

endmodule

// File: rtl/sprite_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_ram_arbiter
//   Shares one 6264 SRAM between a main CPU, a sub CPU and the sprite
//   scanner. CLK_2H selects which CPU owns the current slot; a slot owner
//   with a pending request wins, otherwise the scanner reads. Every RAM
//   control is registered; read data is captured one cycle after the grant,
//   when the matching CPU_ACK bit or SCAN_VALID pulses.
//
//   Build option: define SPRITE_ARB_SCAN_LOCK_EN to hold back CPU writes
//   into the sprite table [BASE, BASE+NUM_SPR*ENTRY_BYTES) while a scan
//   is running.
//
//   Ports
//     CLK_6M, RST_N         : pixel clock, async active-low reset
//     CLK_2H                : slot phase, 1 = main slot, 0 = sub slot
//     VRESET                : frame start, rising edge starts a scan
//     CPU_REQ/WE/A/DI       : per-CPU request (bit/field 0 = sub, 1 = main)
//     CPU_ACK, CPU_DO       : completion pulse and read data
//     RAM_A/CE_N/WE_N/OE_N  : SRAM address and strobes
//     RAM_DO, RAM_DI        : SRAM write data out, read data in
//     SCAN_*                : scanner read results
// ---------------------------------------------------------------------------
module sprite_ram_arbiter
    import sprite_arb_pkg::*;
#(
    parameter logic [12:0] BASE        = BASE_DEFAULT,
    parameter int          NUM_SPR     = NUM_SPR_DEFAULT,
    parameter int          ENTRY_BYTES = ENTRY_BYTES_DEFAULT
) (
    input  logic        CLK_6M,
    input  logic        RST_N,
    input  logic        CLK_2H,
    input  logic        VRESET,
    input  logic [1:0]  CPU_REQ,
    input  logic [1:0]  CPU_WE,
    input  logic [25:0] CPU_A,
    input  logic [15:0] CPU_DI,
    output logic [1:0]  CPU_ACK,
    output logic [7:0]  CPU_DO,
    output logic [12:0] RAM_A,
    output logic        RAM_CE_N,
    output logic        RAM_WE_N,
    output logic        RAM_OE_N,
    output logic [7:0]  RAM_DO,
    input  logic [7:0]  RAM_DI,
    output logic [7:0]  SCAN_D,
    output logic [6:0]  SCAN_IDX,
    output logic [2:0]  SCAN_BYTE,
    output logic        SCAN_VALID,
    output logic        SCAN_DONE
);

    localparam int unsigned WIN_LEN = NUM_SPR * ENTRY_BYTES;

    logic [12:0] ram_a_q, ram_a_d;
    logic        ram_ce_n_q, ram_ce_n_d;
    logic        ram_we_n_q, ram_we_n_d;
    logic        ram_oe_n_q, ram_oe_n_d;
    logic [7:0]  ram_do_q, ram_do_d;
    logic [1:0]  cpu_inflight_q, cpu_inflight_d;
    logic [1:0]  cpu_ack_q, cpu_ack_d;
    logic [7:0]  cpu_do_q, cpu_do_d;

    logic [12:0] sub_a;
    logic [12:0] main_a;
    logic [1:0]  cpu_busy;
    logic [1:0]  lock_blk;
    logic        scan_req;
    logic        scan_gnt;
    logic [12:0] scan_addr;
    grantee_e    grant;

    assign sub_a  = CPU_A[12:0];
    assign main_a = CPU_A[25:13];

    // A CPU is not regranted while its access is in flight or its ACK is
    // still up, so a request held until ACK is served exactly once.
    assign cpu_busy = cpu_inflight_q | cpu_ack_q;

    // ---- Optional scan lock -------------------------------------------------
    always_comb begin
`ifdef SPRITE_ARB_SCAN_LOCK_EN
        lock_blk[0] = scan_req & CPU_WE[0] & in_window(sub_a,  BASE, WIN_LEN);
        lock_blk[1] = scan_req & CPU_WE[1] & in_window(main_a, BASE, WIN_LEN);
`else
        lock_blk = 2'b00;
`endif
    end

    // ---- Grant selection ----------------------------------------------------
    // Only the slot owner may be granted; the other CPU waits for its slot.
    always_comb begin
        grant = GNT_NONE;
        if (CLK_2H) begin
            if (CPU_REQ[1] && !cpu_busy[1] && !lock_blk[1]) grant = GNT_MAIN;
        end else begin
            if (CPU_REQ[0] && !cpu_busy[0] && !lock_blk[0]) grant = GNT_SUB;
        end
        if (grant == GNT_NONE && scan_req) grant = GNT_SCAN;
    end

    assign scan_gnt = (grant == GNT_SCAN);

    // ---- RAM cycle generation -----------------------------------------------
    always_comb begin
        ram_a_d    = ram_a_q;
        ram_do_d   = ram_do_q;
        ram_ce_n_d = 1'b1;
        ram_we_n_d = 1'b1;
        ram_oe_n_d = 1'b1;

        unique case (grant)
            GNT_SUB: begin
                ram_ce_n_d = 1'b0;
                ram_a_d    = sub_a;
                if (CPU_WE[0]) begin
                    ram_we_n_d = 1'b0;
                    ram_do_d   = CPU_DI[7:0];
                end else begin
                    ram_oe_n_d = 1'b0;
                end
            end
            GNT_MAIN: begin
                ram_ce_n_d = 1'b0;
                ram_a_d    = main_a;
                if (CPU_WE[1]) begin
                    ram_we_n_d = 1'b0;
                    ram_do_d   = CPU_DI[15:8];
                end else begin
                    ram_oe_n_d = 1'b0;
                end
            end
            GNT_SCAN: begin
                ram_ce_n_d = 1'b0;
                ram_oe_n_d = 1'b0;
                ram_a_d    = scan_addr;
            end
            GNT_NONE: begin
            end
        endcase

        cpu_inflight_d = {grant == GNT_MAIN, grant == GNT_SUB};
        cpu_ack_d      = cpu_inflight_q;
        cpu_do_d       = (|cpu_inflight_q) ? RAM_DI : cpu_do_q;
    end

    always_ff @(posedge CLK_6M or negedge RST_N) begin
        if (!RST_N) begin
            ram_a_q        <= '0;
            ram_ce_n_q     <= 1'b1;
            ram_we_n_q     <= 1'b1;
            ram_oe_n_q     <= 1'b1;
            ram_do_q       <= '0;
            cpu_inflight_q <= '0;
            cpu_ack_q      <= '0;
            cpu_do_q       <= '0;
        end else begin
            ram_a_q        <= ram_a_d;
            ram_ce_n_q     <= ram_ce_n_d;
            ram_we_n_q     <= ram_we_n_d;
            ram_oe_n_q     <= ram_oe_n_d;
            ram_do_q       <= ram_do_d;
            cpu_inflight_q <= cpu_inflight_d;
            cpu_ack_q      <= cpu_ack_d;
            cpu_do_q       <= cpu_do_d;
        end
    end

    assign RAM_A    = ram_a_q;
    assign RAM_CE_N = ram_ce_n_q;
    assign RAM_WE_N = ram_we_n_q;
    assign RAM_OE_N = ram_oe_n_q;
    assign RAM_DO   = ram_do_q;
    assign CPU_ACK  = cpu_ack_q;
    assign CPU_DO   = cpu_do_q;

    // ---- Sprite scanner -----------------------------------------------------
    sprite_scan_ctrl #(
        .BASE        (BASE),
        .NUM_SPR     (NUM_SPR),
        .ENTRY_BYTES (ENTRY_BYTES)
    ) u_scan (
        .clk        (CLK_6M),
        .rst_n      (RST_N),
        .vreset     (VRESET),
        .scan_gnt   (scan_gnt),
        .ram_di     (RAM_DI),
        .scan_req   (scan_req),
        .scan_addr  (scan_addr),
        .scan_d     (SCAN_D),
        .scan_idx   (SCAN_IDX),
        .scan_byte  (SCAN_BYTE),
        .scan_valid (SCAN_VALID),
        .scan_done  (SCAN_DONE)
    );

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_ram_arbiter
//   Directed bench for sprite_ram_arbiter with a behavioural 8K x 8 SRAM.
//   Inputs change 1 time unit after the rising clock edge; outputs are
//   sampled at the same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_sprite_ram_arbiter;

    logic        CLK_6M;
    logic        RST_N;
    logic        CLK_2H;
    logic        VRESET;
    logic [1:0]  CPU_REQ;
    logic [1:0]  CPU_WE;
    logic [25:0] CPU_A;
    logic [15:0] CPU_DI;
    logic [1:0]  CPU_ACK;
    logic [7:0]  CPU_DO;
    logic [12:0] RAM_A;
    logic        RAM_CE_N;
    logic        RAM_WE_N;
    logic        RAM_OE_N;
    logic [7:0]  RAM_DO;
    logic [7:0]  RAM_DI;
    logic [7:0]  SCAN_D;
    logic [6:0]  SCAN_IDX;
    logic [2:0]  SCAN_BYTE;
    logic        SCAN_VALID;
    logic        SCAN_DONE;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:8191];

    sprite_ram_arbiter dut (
        .CLK_6M     (CLK_6M),
        .RST_N      (RST_N),
        .CLK_2H     (CLK_2H),
        .VRESET     (VRESET),
        .CPU_REQ    (CPU_REQ),
        .CPU_WE     (CPU_WE),
        .CPU_A      (CPU_A),
        .CPU_DI     (CPU_DI),
        .CPU_ACK    (CPU_ACK),
        .CPU_DO     (CPU_DO),
        .RAM_A      (RAM_A),
        .RAM_CE_N   (RAM_CE_N),
        .RAM_WE_N   (RAM_WE_N),
        .RAM_OE_N   (RAM_OE_N),
        .RAM_DO     (RAM_DO),
        .RAM_DI     (RAM_DI),
        .SCAN_D     (SCAN_D),
        .SCAN_IDX   (SCAN_IDX),
        .SCAN_BYTE  (SCAN_BYTE),
        .SCAN_VALID (SCAN_VALID),
        .SCAN_DONE  (SCAN_DONE)
    );

    initial CLK_6M = 1'b0;
    always #5 CLK_6M = ~CLK_6M;

    // SRAM model: asynchronous read, write captured at the end of a write cycle.
    assign RAM_DI = mem[RAM_A];
    always @(posedge CLK_6M) begin
        if (!RAM_CE_N && !RAM_WE_N) mem[RAM_A] <= RAM_DO;
    end

    function automatic logic [7:0] pat(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]};
    endfunction

    // Expected scan data after the sub CPU wrote 8'h3C to 13'h1805.
    function automatic logic [7:0] exp_scan(input logic [12:0] a);
        return (a == 13'h1805) ? 8'h3C : pat(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_6M);
        #1;
    endtask

    task automatic drive_idle();
        CPU_REQ = 2'b00;
        CPU_WE  = 2'b00;
        CPU_A   = '0;
        CPU_DI  = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants, gcnt, vcnt, aerr, ierr, derr, werr, dcnt;
        int found, seen40, got, ack_cycle, ack_seen, ack_after_done, done_seen, acks;
        logic [12:0] exp_a, wr_a;
        logic [7:0]  wr_do;
        logic [9:0]  first_pos, last_pos;

        for (int i = 0; i < 8192; i++) mem[i] = pat(13'(i));
        mem[13'h0123] = 8'hA5;

        // ---------------- reset state ----------------
        RST_N  = 1'b0;
        CLK_2H = 1'b1;
        VRESET = 1'b0;
        drive_idle();
        repeat (3) tick();
        check("rst_ctrl",   32'({RAM_CE_N, RAM_WE_N, RAM_OE_N}), 32'h7);
        check("rst_ram_a",  32'(RAM_A), 32'h0);
        check("rst_ram_do", 32'(RAM_DO), 32'h0);
        check("rst_ack",    32'(CPU_ACK), 32'h0);
        check("rst_cpu_do", 32'(CPU_DO), 32'h0);
        check("rst_scan",   32'({SCAN_D, SCAN_IDX, SCAN_BYTE, SCAN_VALID, SCAN_DONE}), 32'h0);
        RST_N = 1'b1;
        tick();
        check("idle_no_grant", 32'(RAM_CE_N), 32'h1);

        // ---------------- main read 0x0123 in main slot ----------------
        CPU_REQ = 2'b10;
        CPU_WE  = 2'b00;
        CPU_A   = {13'h0123, 13'h0000};
        tick();
        check("rd_main_addr",  32'(RAM_A), 32'h0123);
        check("rd_main_ctrl",  32'({RAM_CE_N, RAM_WE_N, RAM_OE_N}), 32'h2);
        check("rd_main_early", 32'(CPU_ACK), 32'h0);
        tick();
        check("rd_main_ack",        32'(CPU_ACK), 32'h2);
        check("rd_main_do",         32'(CPU_DO), 32'hA5);
        check("rd_main_no_regrant", 32'(RAM_CE_N), 32'h1);
        drive_idle();
        tick();
        check("rd_main_ack_pulse", 32'(CPU_ACK), 32'h0);

        // ---------------- sub write outside then inside its slot ----------------
        CPU_REQ = 2'b01;
        CPU_WE  = 2'b01;
        CPU_A   = {13'h0000, 13'h1805};
        CPU_DI  = {8'h00, 8'h3C};
        grants  = 0;
        repeat (3) begin
            tick();
            if (!RAM_CE_N) grants++;
        end
        check("wr_sub_wait_slot", 32'(grants), 32'h0);
        CLK_2H = 1'b0;
        tick();
        check("wr_sub_ctrl", 32'({RAM_CE_N, RAM_WE_N, RAM_OE_N}), 32'h1);
        check("wr_sub_addr", 32'(RAM_A), 32'h1805);
        check("wr_sub_data", 32'(RAM_DO), 32'h3C);
        tick();
        check("wr_sub_ack",    32'(CPU_ACK), 32'h1);
        check("wr_sub_single", 32'({RAM_CE_N, RAM_WE_N, RAM_OE_N}), 32'h7);
        drive_idle();
        CLK_2H = 1'b1;
        tick();
        check("wr_sub_ack_pulse", 32'(CPU_ACK), 32'h0);

        // ---------------- full scan with CPUs idle ----------------
        VRESET = 1'b1;
        tick();
        VRESET = 1'b0;
        gcnt = 0; vcnt = 0; aerr = 0; ierr = 0; derr = 0; werr = 0; dcnt = 0;
        last_pos = '0;
        for (int c = 0; c < 1100 && dcnt == 0; c++) begin
            tick();
            if (!RAM_CE_N) begin
                exp_a = 13'h1800 + 13'(gcnt);
                if (RAM_A !== exp_a) aerr++;
                if (!RAM_WE_N) werr++;
                gcnt++;
            end
            if (SCAN_VALID) begin
                exp_a = 13'h1800 + 13'(vcnt);
                if ({SCAN_IDX, SCAN_BYTE} !== exp_a[9:0]) ierr++;
                if (SCAN_D !== exp_scan(exp_a)) derr++;
                if (SCAN_DONE) last_pos = {SCAN_IDX, SCAN_BYTE};
                vcnt++;
            end
            if (SCAN_DONE) dcnt++;
        end
        check("scan_valid_count", 32'(vcnt), 32'd1024);
        check("scan_grant_count", 32'(gcnt), 32'd1024);
        check("scan_addr_errors", 32'(aerr), 32'h0);
        check("scan_pos_errors",  32'(ierr), 32'h0);
        check("scan_data_errors", 32'(derr), 32'h0);
        check("scan_no_writes",   32'(werr), 32'h0);
        check("scan_done_count",  32'(dcnt), 32'h1);
        check("scan_last_pos",    32'(last_pos), 32'h3FF);
        tick();
        tick();
        check("scan_idle_after_done", 32'(RAM_CE_N), 32'h1);

        // ---------------- restart during scan at idx 40 ----------------
        VRESET = 1'b1;
        tick();
        VRESET = 1'b0;
        found = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (SCAN_VALID && SCAN_IDX == 7'd39 && SCAN_BYTE == 3'd7) begin
                found = 1;
                break;
            end
        end
        check("restart_reach_idx39", 32'(found), 32'h1);
        VRESET = 1'b1;
        tick();
        VRESET = 1'b0;
        seen40 = 0;
        got = 0;
        first_pos = 10'h3FF;
        for (int c = 0; c < 20; c++) begin
            if (SCAN_VALID) begin
                if (SCAN_IDX == 7'd40) begin
                    seen40 = 1;
                end else begin
                    first_pos = {SCAN_IDX, SCAN_BYTE};
                    got = 1;
                    break;
                end
            end
            tick();
        end
        check("restart_no_idx40",    32'(seen40), 32'h0);
        check("restart_got_valid",   32'(got), 32'h1);
        check("restart_first_pos",   32'(first_pos), 32'h0);

        // ---------------- main write into sprite table during scan ----------------
        CLK_2H  = 1'b1;
        CPU_REQ = 2'b10;
        CPU_WE  = 2'b10;
        CPU_A   = {13'h1810, 13'h0000};
        CPU_DI  = {8'hC3, 8'h00};
        wr_a    = '0;
        wr_do   = '0;
`ifdef SPRITE_ARB_SCAN_LOCK_EN
        ack_seen = 0;
        ack_after_done = 0;
        done_seen = 0;
        for (int c = 0; c < 1300; c++) begin
            tick();
            if (!RAM_CE_N && !RAM_WE_N) begin
                wr_a  = RAM_A;
                wr_do = RAM_DO;
            end
            if (SCAN_DONE) done_seen = 1;
            if (CPU_ACK[1]) begin
                ack_seen = 1;
                ack_after_done = done_seen;
                break;
            end
        end
        check("lock_ack_seen",       32'(ack_seen), 32'h1);
        check("lock_ack_after_done", 32'(ack_after_done), 32'h1);
        check("lock_wr_addr",        32'(wr_a), 32'h1810);
        check("lock_wr_data",        32'(wr_do), 32'hC3);
        drive_idle();
`else
        ack_cycle = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (!RAM_CE_N && !RAM_WE_N) begin
                wr_a  = RAM_A;
                wr_do = RAM_DO;
            end
            if (CPU_ACK[1]) begin
                ack_cycle = c;
                break;
            end
        end
        check("nolock_ack_latency", 32'(ack_cycle), 32'd2);
        check("nolock_wr_addr",     32'(wr_a), 32'h1810);
        check("nolock_wr_data",     32'(wr_do), 32'hC3);
        drive_idle();
        done_seen = 0;
        for (int c = 0; c < 1300; c++) begin
            tick();
            if (SCAN_DONE) begin
                done_seen = 1;
                break;
            end
        end
        check("nolock_scan_completes", 32'(done_seen), 32'h1);
`endif
        tick();
        tick();

        // ---------------- reset in the middle of a main read ----------------
        CLK_2H  = 1'b1;
        CPU_REQ = 2'b10;
        CPU_WE  = 2'b00;
        CPU_A   = {13'h0123, 13'h0000};
        tick();
        check("rst_mid_granted", 32'(RAM_CE_N), 32'h0);
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_mid_ctrl",   32'({RAM_CE_N, RAM_WE_N, RAM_OE_N}), 32'h7);
        check("rst_mid_ram_a",  32'(RAM_A), 32'h0);
        check("rst_mid_ack",    32'(CPU_ACK), 32'h0);
        check("rst_mid_cpu_do", 32'(CPU_DO), 32'h0);
        drive_idle();
        acks = 0;
        repeat (2) begin
            tick();
            if (CPU_ACK != 2'b00) acks++;
        end
        RST_N = 1'b1;
        repeat (3) begin
            tick();
            if (CPU_ACK != 2'b00) acks++;
        end
        check("rst_mid_no_ack", 32'(acks), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
